// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider and its
// combinational step cell.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_DVD_W = 8;
  localparam int DIV_DVS_W = 4;

  // Wide all-ones pattern; users slice off their own quotient width.
  localparam logic [63:0] DIV_DBZ_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int DVS_W = DIV_DVS_W
) (
  input  logic [DVS_W:0]   prem_i,
  input  logic             q_msb_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic [DVS_W:0]   prem_o,
  output logic             q_bit_o
);

  logic [DVS_W+1:0] shifted;

  // prem_i stays below the divisor, so the full-width compare equals the
  // sign test of the trial subtraction and the result fits DVS_W+1 bits.
  assign shifted = {prem_i, q_msb_i};
  assign q_bit_o = (shifted >= {2'b00, divisor_i});
  assign prem_o  = (DVS_W+1)'(q_bit_o ? (shifted - {2'b00, divisor_i}) : shifted);

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring unsigned divider, one quotient bit per clock,
// with valid/ready handshakes on operand and result sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int DVD_W = DIV_DVD_W,
  parameter int DVS_W = DIV_DVS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(DVD_W);

  div_state_t       state_q, state_d;
  logic [DVS_W:0]   prem_q, prem_d;
  logic [DVD_W-1:0] quot_q, quot_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [DVS_W:0]   step_prem;
  logic             step_qbit;

  div_step #(
    .DVS_W(DVS_W)
  ) u_step (
    .prem_i   (prem_q),
    .q_msb_i  (quot_q[DVD_W-1]),
    .divisor_i(dvs_q),
    .prem_o   (step_prem),
    .q_bit_o  (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d = divisor;
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = DIV_DBZ_QUOT[DVD_W-1:0];
            prem_d  = {1'b0, dividend[DVS_W-1:0]};
            cnt_d   = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            quot_d  = dividend;
            prem_d  = '0;
            cnt_d   = CNT_W'(DVD_W - 1);
            dbz_d   = 1'b0;
          end
        end
      end
      CALC: begin
        // Quotient register doubles as the dividend shifter: MSB out, result bit in.
        prem_d = step_prem;
        quot_d = {quot_q[DVD_W-2:0], step_qbit};
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prem_q  <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = prem_q[DVS_W-1:0];
  assign div_by_zero = dbz_q;

endmodule
